// File: rtl/inta_sequencer_pkg.sv
// Shared constants for the 8086-mode INTA sequencer: FSM encodings, INTA polarity, vector width.
package inta_sequencer_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] P1_LOW  = 3'd1;
    localparam logic [2:0] GAP     = 3'd2;
    localparam logic [2:0] P2_LOW  = 3'd3;
    localparam logic [2:0] RECOVER = 3'd4;

    localparam logic INTA_ACTIVE = 1'b0;
    localparam int   VECTOR_W    = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// PIC-side and CPU-side signals of the INTA sequencer; master is the sequencer itself.
interface inta_sequencer_if;
    import inta_sequencer_pkg::*;

    logic                int_in;
    logic                intr_enable;
    logic [VECTOR_W-1:0] data_bus;
    logic                inta_n;
    logic [VECTOR_W-1:0] vec_data;
    logic                vec_valid;
    logic                vec_ready;
    logic                busy;

    modport master (
        input  int_in, intr_enable, data_bus, vec_ready,
        output inta_n, vec_data, vec_valid, busy
    );

    modport slave (
        output int_in, intr_enable, data_bus, vec_ready,
        input  inta_n, vec_data, vec_valid, busy
    );

endinterface

// File: rtl/int_synchronizer.sv
// Two-flop synchronizer bringing the asynchronous PIC INT line into the clk domain.
// Latency: 2 clk edges. No backpressure.
module int_synchronizer (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/inta_sequencer.sv
// Drives the two-pulse 8086 INTA sequence to the PIC and hands the captured vector to the CPU.
// Latency: INT high before edge N -> INTA low after edge N+2; vector valid after 2*PULSE+GAP cycles.
// Backpressure: while vec_valid is held (vec_ready low) no new sequence starts.
module inta_sequencer
    import inta_sequencer_pkg::*;
#(
    parameter int PULSE_CYCLES   = 2,
    parameter int GAP_CYCLES     = 2,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    inta_sequencer_if.master bus
);

    localparam int CNT_W = $clog2(max3(PULSE_CYCLES, GAP_CYCLES, RECOVER_CYCLES) + 1);

    // Counters load duration-1 on entry and leave the state when they reach zero.
    localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYCLES - 1);

    logic                int_s;
    logic [2:0]          state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [VECTOR_W-1:0] vec_data_q,  vec_data_d;
    logic                vec_valid_q, vec_valid_d;
    logic                inta_n_q,    inta_n_d;
    logic                busy_q,      busy_d;

    int_synchronizer u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.int_in),
        .q   (int_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_data_d  = vec_data_q;
        vec_valid_d = vec_valid_q;

        if (vec_valid_q && bus.vec_ready) begin
            vec_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Registered vec_valid gates the start, so a consume and a start never share an edge.
                if (int_s && bus.intr_enable && !vec_valid_q) begin
                    state_d = P1_LOW;
                    cnt_d   = PULSE_LD;
                end
            end
            P1_LOW: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = P2_LOW;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            P2_LOW: begin
                if (cnt_q == '0) begin
                    state_d     = RECOVER;
                    cnt_d       = RECOVER_LD;
                    vec_data_d  = bus.data_bus;
                    vec_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the pins come straight from flops.
        inta_n_d = ((state_d == P1_LOW) || (state_d == P2_LOW)) ? INTA_ACTIVE : ~INTA_ACTIVE;
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vec_data_q  <= '0;
            vec_valid_q <= 1'b0;
            inta_n_q    <= ~INTA_ACTIVE;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_data_q  <= vec_data_d;
            vec_valid_q <= vec_valid_d;
            inta_n_q    <= inta_n_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.inta_n    = inta_n_q;
    assign bus.vec_data  = vec_data_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.busy      = busy_q;

endmodule
